// File: rtl/ddr_ui_responder.sv
// Memory-side responder: queues cache commands/beats and drives a DDR UI.
// Optional sticky protocol checker under `DDR_RESPONDER_CHECK_EN.

module ddr_ui_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic                 rd_i,
  output logic [W-1:0]         rdata_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [$clog2(D):0]   count_o
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          we, re;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(D));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign we      = wr_i & ~full_o;
  assign re      = rd_i & ~empty_o;

  // Pointer and occupancy update; full writes are dropped.
  always_comb begin
    wptr_d  = wptr_q + AW'(we);
    rptr_d  = rptr_q + AW'(re);
    count_d = count_q + (AW+1)'(we) - (AW+1)'(re);
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module ddr_ui_responder #(
  parameter int CMD_DEPTH   = 8,
  parameter int WDATA_DEPTH = 8,
  parameter int RDATA_DEPTH = 8,
  parameter int ADDR_WIDTH  = 27
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  write_i,
  input  logic                  read_i,
  input  logic                  push_i,
  input  logic [63:0]           write_data_i,
  input  logic [7:0]            write_mask_i,
  input  logic                  pull_i,
  output logic [1:0][31:0]      read_data_o,
  output logic                  read_valid_o,
  input  logic                  done_i,
  output logic                  ready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [2:0]            mem_cmd_o,
  output logic                  mem_en_o,
  input  logic                  mem_rdy_i,
  output logic [63:0]           mem_wdf_data_o,
  output logic [7:0]            mem_wdf_mask_o,
  output logic                  mem_wdf_wren_o,
  output logic                  mem_wdf_end_o,
  input  logic                  mem_wdf_rdy_i,
  input  logic [63:0]           mem_rd_data_i,
  input  logic                  mem_rd_data_valid_i
`ifdef DDR_RESPONDER_CHECK_EN
  ,
  output logic                  protocol_error_o
`endif
);
  localparam int OW = $clog2(RDATA_DEPTH) + 1;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int DW = $clog2(WDATA_DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                cmd_done_q, cmd_done_d;
  logic                dat_done_q, dat_done_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                ready_q, ready_d;
  logic                burst_open_q, burst_open_d;

  logic                cmd_wr, cmd_pop, cmd_empty, cmd_full;
  logic [ADDR_WIDTH:0] cmd_head;
  logic [CW-1:0]       cmd_count;
  logic                head_rd;
  logic [ADDR_WIDTH-1:0] head_addr;

  logic                wdf_pop, wdf_empty, wdf_full;
  logic [71:0]         wdf_head;
  logic [DW-1:0]       wdf_count;

  logic                r_empty, r_full;
  logic [63:0]         r_head;
  logic [OW-1:0]       r_count;

  logic                rd_inc, rd_ret, resv_ok;
  logic                cmd_fire, dat_fire;

  assign cmd_wr    = write_i | read_i;
  assign head_rd   = cmd_head[ADDR_WIDTH];
  assign head_addr = {cmd_head[ADDR_WIDTH-1:2], 2'b00};

  ddr_ui_fifo #(.W(ADDR_WIDTH+1), .D(CMD_DEPTH)) u_cmd (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_i    (cmd_wr),
    .wdata_i ({read_i & ~write_i, address_i[ADDR_WIDTH-1:2], 2'b00}),
    .rd_i    (cmd_pop),
    .rdata_o (cmd_head),
    .empty_o (cmd_empty),
    .full_o  (cmd_full),
    .count_o (cmd_count)
  );

  ddr_ui_fifo #(.W(72), .D(WDATA_DEPTH)) u_wdf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_i    (push_i),
    .wdata_i ({write_mask_i, write_data_i}),
    .rd_i    (wdf_pop),
    .rdata_o (wdf_head),
    .empty_o (wdf_empty),
    .full_o  (wdf_full),
    .count_o (wdf_count)
  );

  ddr_ui_fifo #(.W(64), .D(RDATA_DEPTH)) u_rdf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_i    (rd_ret),
    .wdata_i (mem_rd_data_i),
    .rd_i    (pull_i),
    .rdata_o (r_head),
    .empty_o (r_empty),
    .full_o  (r_full),
    .count_o (r_count)
  );

  // UI outputs are all zero outside the command states.
  assign mem_en_o       = ((state_q == S_WR) & ~cmd_done_q) |
                          (state_q == S_RD);
  assign mem_cmd_o      = (state_q == S_RD) ? 3'b001 : 3'b000;
  assign mem_addr_o     = (state_q != S_IDLE) ? head_addr : '0;
  assign mem_wdf_wren_o = (state_q == S_WR) & ~dat_done_q;
  assign mem_wdf_end_o  = mem_wdf_wren_o;
  assign mem_wdf_data_o = mem_wdf_wren_o ? wdf_head[63:0] : '0;
  assign mem_wdf_mask_o = mem_wdf_wren_o ? ~wdf_head[71:64] : '0;

  assign cmd_fire = mem_en_o & mem_rdy_i;
  assign dat_fire = mem_wdf_wren_o & mem_wdf_rdy_i;

  // Beats arriving with nothing outstanding are stale (pre-reset) and dropped.
  assign rd_ret  = mem_rd_data_valid_i & (outst_q != '0);
  assign resv_ok = ({1'b0, outst_q} + {1'b0, r_count}) <
                   (OW+1)'(RDATA_DEPTH);

  assign read_valid_o   = ~r_empty;
  assign read_data_o[0] = r_empty ? 32'h0 : r_head[31:0];
  assign read_data_o[1] = r_empty ? 32'h0 : r_head[63:32];
  assign ready_o        = ready_q;

  // Command sequencer: one UI command per queued entry.
  always_comb begin
    state_d    = state_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    cmd_pop    = 1'b0;
    wdf_pop    = 1'b0;
    rd_inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!cmd_empty) begin
          if (!head_rd && !wdf_empty) state_d = S_WR;
          else if (head_rd && resv_ok) state_d = S_RD;
        end
      end
      S_WR: begin
        if ((cmd_done_q | cmd_fire) && (dat_done_q | dat_fire)) begin
          cmd_pop    = 1'b1;
          wdf_pop    = 1'b1;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cmd_done_d = cmd_done_q | cmd_fire;
          dat_done_d = dat_done_q | dat_fire;
        end
      end
      S_RD: begin
        if (mem_rdy_i) begin
          cmd_pop = 1'b1;
          rd_inc  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding reads, ready flag and burst tracking.
  always_comb begin
    outst_d = outst_q;
    if (rd_inc && !rd_ret) begin
      if (outst_q != OW'(RDATA_DEPTH)) outst_d = outst_q + 1'b1;
    end else if (!rd_inc && rd_ret) begin
      outst_d = outst_q - 1'b1;
    end
    ready_d = cmd_empty & wdf_empty & r_empty & (outst_q == '0) &
              (state_q == S_IDLE) & ~(write_i | read_i | push_i);
    burst_open_d = read_i | (burst_open_q & ~done_i);
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cmd_done_q   <= 1'b0;
      dat_done_q   <= 1'b0;
      outst_q      <= '0;
      ready_q      <= 1'b0;
      burst_open_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_done_q   <= cmd_done_d;
      dat_done_q   <= dat_done_d;
      outst_q      <= outst_d;
      ready_q      <= ready_d;
      burst_open_q <= burst_open_d;
    end
  end

`ifdef DDR_RESPONDER_CHECK_EN
  logic err_q, err_d;

  assign protocol_error_o = err_q;

  // Sticky protocol violation flag.
  always_comb begin
    err_d = err_q |
            (write_i & read_i) |
            (cmd_wr & cmd_full) |
            (push_i & wdf_full) |
            (rd_ret & r_full) |
            (pull_i & r_empty) |
            (mem_rd_data_valid_i & (outst_q == '0)) |
            (done_i & ~burst_open_q);
  end

  // Error register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{address_i[1:0], done_i, burst_open_q, cmd_full,
                       wdf_full, r_full, cmd_count, wdf_count};
endmodule

// File: tb/tb_ddr_ui_responder.sv
// Directed bench for ddr_ui_responder with a latency-5 UI read model.
// Read beat data = (address >> 2) + 2, so 0x20..0x2C return 0xA..0xD.

module tb_ddr_ui_responder;
  localparam int LAT = 5;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [26:0]     address_i;
  logic            write_i, read_i, push_i, pull_i, done_i;
  logic [63:0]     write_data_i;
  logic [7:0]      write_mask_i;
  logic [1:0][31:0] read_data_o;
  logic            read_valid_o, ready_o;
  logic [26:0]     mem_addr_o;
  logic [2:0]      mem_cmd_o;
  logic            mem_en_o, mem_rdy_i;
  logic [63:0]     mem_wdf_data_o;
  logic [7:0]      mem_wdf_mask_o;
  logic            mem_wdf_wren_o, mem_wdf_end_o, mem_wdf_rdy_i;
  logic [63:0]     mem_rd_data_i;
  logic            mem_rd_data_valid_i;
`ifdef DDR_RESPONDER_CHECK_EN
  logic            protocol_error_o;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_issued = 0;
  int base;
  logic ok;

  typedef struct {
    int          due;
    logic [63:0] d;
  } ret_t;
  ret_t rq[$];

  always #5 clk_i = ~clk_i;

  ddr_ui_responder dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .address_i           (address_i),
    .write_i             (write_i),
    .read_i              (read_i),
    .push_i              (push_i),
    .write_data_i        (write_data_i),
    .write_mask_i        (write_mask_i),
    .pull_i              (pull_i),
    .read_data_o         (read_data_o),
    .read_valid_o        (read_valid_o),
    .done_i              (done_i),
    .ready_o             (ready_o),
    .mem_addr_o          (mem_addr_o),
    .mem_cmd_o           (mem_cmd_o),
    .mem_en_o            (mem_en_o),
    .mem_rdy_i           (mem_rdy_i),
    .mem_wdf_data_o      (mem_wdf_data_o),
    .mem_wdf_mask_o      (mem_wdf_mask_o),
    .mem_wdf_wren_o      (mem_wdf_wren_o),
    .mem_wdf_end_o       (mem_wdf_end_o),
    .mem_wdf_rdy_i       (mem_wdf_rdy_i),
    .mem_rd_data_i       (mem_rd_data_i),
    .mem_rd_data_valid_i (mem_rd_data_valid_i)
`ifdef DDR_RESPONDER_CHECK_EN
    ,
    .protocol_error_o    (protocol_error_o)
`endif
  );

  // UI read model: accepted read returns (addr>>2)+2 after LAT cycles.
  initial begin
    mem_rd_data_valid_i = 1'b0;
    mem_rd_data_i = '0;
    forever begin
      @(posedge clk_i);
      if (rst_n_i && mem_en_o && mem_rdy_i && mem_cmd_o == 3'b001) begin
        rq.push_back('{cyc + LAT, 64'(mem_addr_o >> 2) + 64'd2});
        rd_issued++;
      end
      cyc++;
      #1;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_rd_data_valid_i = 1'b1;
        mem_rd_data_i = rq[0].d;
        void'(rq.pop_front());
      end else begin
        mem_rd_data_valid_i = 1'b0;
        mem_rd_data_i = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 60 && !ready_o; i++) tick();
    chk(tag, 64'(ready_o), 64'd1);
  endtask

  task automatic pull_expect(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 60 && !read_valid_o; i++) tick();
    chk({tag, "_valid"}, 64'(read_valid_o), 64'd1);
    chk(tag, {read_data_o[1], read_data_o[0]}, exp);
    pull_i = 1'b1;
    tick();
    pull_i = 1'b0;
  endtask

  task automatic send_read(input logic [26:0] a);
    read_i = 1'b1;
    address_i = a;
    tick();
    read_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    rst_n_i = 1'b0;
    address_i = '0;
    write_i = 1'b0;
    read_i = 1'b0;
    push_i = 1'b0;
    pull_i = 1'b0;
    done_i = 1'b0;
    write_data_i = '0;
    write_mask_i = '0;
    mem_rdy_i = 1'b1;
    mem_wdf_rdy_i = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_en", 64'(mem_en_o), 64'd0);
    chk("rst_wren", 64'(mem_wdf_wren_o), 64'd0);
    chk("rst_valid", 64'(read_valid_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    rst_n_i = 1'b1;
    tick();
    chk("ready_after_rst", 64'(ready_o), 64'd1);

    // Single write
    write_i = 1'b1;
    address_i = 27'h0000010;
    push_i = 1'b1;
    write_data_i = 64'h11223344_55667788;
    write_mask_i = 8'h0F;
    tick();
    write_i = 1'b0;
    push_i = 1'b0;
    chk("wr_ready_low", 64'(ready_o), 64'd0);
    chk("wr_en_idle", 64'(mem_en_o), 64'd0);
    tick();
    chk("wr_en", 64'(mem_en_o), 64'd1);
    chk("wr_wren", 64'(mem_wdf_wren_o), 64'd1);
    chk("wr_cmd", 64'(mem_cmd_o), 64'd0);
    chk("wr_addr", 64'(mem_addr_o), 64'h10);
    chk("wr_mask", 64'(mem_wdf_mask_o), 64'hF0);
    chk("wr_end", 64'(mem_wdf_end_o), 64'd1);
    chk("wr_data", mem_wdf_data_o, 64'h11223344_55667788);
    tick();
    chk("wr_en_drop", 64'(mem_en_o), 64'd0);
    chk("wr_wren_drop", 64'(mem_wdf_wren_o), 64'd0);
    tick();
    chk("wr_ready_back", 64'(ready_o), 64'd1);

    // Split handshake: data accepted 3 cycles after command
    mem_wdf_rdy_i = 1'b0;
    write_i = 1'b1;
    address_i = 27'h0000043;
    push_i = 1'b1;
    write_data_i = 64'hDEAD_BEEF_0000_0001;
    write_mask_i = 8'hFF;
    tick();
    write_i = 1'b0;
    push_i = 1'b0;
    tick();
    chk("sp_en_c0", 64'(mem_en_o), 64'd1);
    chk("sp_addr", 64'(mem_addr_o), 64'h40);
    chk("sp_wren_c0", 64'(mem_wdf_wren_o), 64'd1);
    tick();
    chk("sp_en_c1", 64'(mem_en_o), 64'd0);
    chk("sp_wren_c1", 64'(mem_wdf_wren_o), 64'd1);
    tick();
    chk("sp_wren_c2", 64'(mem_wdf_wren_o), 64'd1);
    tick();
    chk("sp_wren_c3", 64'(mem_wdf_wren_o), 64'd1);
    chk("sp_data", mem_wdf_data_o, 64'hDEAD_BEEF_0000_0001);
    chk("sp_mask", 64'(mem_wdf_mask_o), 64'h00);
    chk("sp_not_ready", 64'(ready_o), 64'd0);
    mem_wdf_rdy_i = 1'b1;
    tick();
    chk("sp_wren_drop", 64'(mem_wdf_wren_o), 64'd0);
    chk("sp_en_stay_low", 64'(mem_en_o), 64'd0);
    wait_ready("sp_ready");

    // Read burst of 4
    base = rd_issued;
    send_read(27'h20);
    send_read(27'h24);
    send_read(27'h28);
    send_read(27'h2C);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    pull_expect("burst0", 64'hA);
    pull_expect("burst1", 64'hB);
    pull_expect("burst2", 64'hC);
    pull_expect("burst3", 64'hD);
    chk("burst_issued", 64'(rd_issued - base), 64'd4);
    chk("burst_empty", 64'(read_valid_o), 64'd0);
    wait_ready("burst_ready");

    // Backpressure with 3 queued reads
    base = rd_issued;
    mem_rdy_i = 1'b0;
    send_read(27'h20);
    send_read(27'h24);
    send_read(27'h28);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(mem_en_o && mem_addr_o == 27'h20 && mem_cmd_o == 3'b001))
        ok = 1'b0;
      tick();
    end
    chk("bp_hold", 64'(ok), 64'd1);
    chk("bp_none_issued", 64'(rd_issued - base), 64'd0);
    mem_rdy_i = 1'b1;
    pull_expect("bp0", 64'hA);
    pull_expect("bp1", 64'hB);
    pull_expect("bp2", 64'hC);
    wait_ready("bp_ready");

    // Read-FIFO reservation: 10 reads, depth 8
    base = rd_issued;
    for (int i = 0; i < 10; i++) send_read(27'(27'h100 + 4 * i));
    for (int i = 0; i < 60; i++) tick();
    chk("resv_8", 64'(rd_issued - base), 64'd8);
    chk("resv_ready_low", 64'(ready_o), 64'd0);
    pull_expect("resv0", 64'h42);
    for (int i = 0; i < 20; i++) tick();
    chk("resv_9", 64'(rd_issued - base), 64'd9);
    for (int i = 1; i < 10; i++) pull_expect("resv", 64'(64'h42 + i));
    chk("resv_10", 64'(rd_issued - base), 64'd10);
    wait_ready("resv_ready");

    // Simultaneous write and read: write wins
    base = rd_issued;
    write_i = 1'b1;
    read_i = 1'b1;
    address_i = 27'h80;
    push_i = 1'b1;
    write_data_i = 64'hCAFE;
    write_mask_i = 8'hFF;
    tick();
    write_i = 1'b0;
    read_i = 1'b0;
    push_i = 1'b0;
    tick();
    chk("both_en", 64'(mem_en_o), 64'd1);
    chk("both_cmd", 64'(mem_cmd_o), 64'd0);
    chk("both_addr", 64'(mem_addr_o), 64'h80);
    wait_ready("both_ready");
    chk("both_no_read", 64'(rd_issued - base), 64'd0);

    // Reset with a read in flight: stale beat discarded
    send_read(27'h200);
    tick();
    chk("rr_en", 64'(mem_en_o), 64'd1);
    tick();
    rst_n_i = 1'b0;
    tick();
    chk("rr_in_rst_en", 64'(mem_en_o), 64'd0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rr_discard", 64'(read_valid_o), 64'd0);
    chk("rr_ready", 64'(ready_o), 64'd1);

    // Pull on empty read FIFO
    do_reset();
`ifdef DDR_RESPONDER_CHECK_EN
    chk("err_clear", 64'(protocol_error_o), 64'd0);
`endif
    pull_i = 1'b1;
    tick();
    pull_i = 1'b0;
    chk("empty_pull_valid", 64'(read_valid_o), 64'd0);
`ifdef DDR_RESPONDER_CHECK_EN
    chk("err_set", 64'(protocol_error_o), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("err_sticky", 64'(protocol_error_o), 64'd1);
`endif
    tick();
    chk("empty_pull_ready", 64'(ready_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_ui_responder.md
Name: ddr_ui_responder

Overview:
- Memory-side end of the cache↔DDR command/data link.
- Accepts write/read commands, 64-bit write beats and read-data pulls from the cache-side DDR interface, and drives them into a native DDR controller user interface (one 64-bit beat per command).
- Returns read data in issue order through a read FIFO.
- Sits between the cache DDR interface and the DDR controller IP.

Parameters:
- CMD_DEPTH, 8, command FIFO entries (power of 2, ≥ largest cache burst / 2)
- WDATA_DEPTH, 8, write-data FIFO entries (power of 2)
- RDATA_DEPTH, 8, read-data FIFO entries (power of 2)
- ADDR_WIDTH, 27, address width (16-bit units; one 64-bit beat = 4 units)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- address_i  in  ADDR_WIDTH  command address, low 2 bits ignored (forced 0 downstream)
- write_i  in  1  enqueue write command
- read_i  in  1  enqueue read command
- push_i  in  1  enqueue write beat
- write_data_i  in  64  write beat
- write_mask_i  in  8  byte enables, 1 = write
- pull_i  in  1  pop read-FIFO head
- read_data_o  out  2x32  read-FIFO head; [0] = low word
- read_valid_o  out  1  read FIFO non-empty
- done_i  in  1  cache finished issuing a read burst (informational; clears burst_open)
- ready_o  out  1  responder fully idle, new burst may start
- mem_addr_o  out  ADDR_WIDTH  UI address
- mem_cmd_o  out  3  UI command: 3'b000 write, 3'b001 read
- mem_en_o  out  1  UI command valid
- mem_rdy_i  in  1  UI command accept
- mem_wdf_data_o  out  64  UI write data
- mem_wdf_mask_o  out  8  UI mask, 1 = masked (inverse of write_mask_i)
- mem_wdf_wren_o  out  1  UI write-data valid
- mem_wdf_end_o  out  1  equals mem_wdf_wren_o (single-beat bursts)
- mem_wdf_rdy_i  in  1  UI write-data accept
- mem_rd_data_i  in  64  UI read data
- mem_rd_data_valid_i  in  1  UI read data valid

Behaviour:
- Reset:
  - All FIFOs empty; counters 0; FSM IDLE.
  - All outputs 0, including ready_o.
  - ready_o rises the first clock after reset release.
- Command FIFO entry: {is_read, address}, written on write_i|read_i.
  - Both asserted in the same cycle: write enqueued, read dropped.
- Write-data FIFO entry: {mask, data}, written on push_i.
- FIFO writes when full are dropped; contents are preserved.
- FSM:
  - IDLE: when cmd FIFO non-empty:
    - Head is a write and wdata FIFO is non-empty → WR_CMD.
    - Head is a write and wdata FIFO is empty → stay in IDLE.
    - Head is a read and (outstanding + rfifo_count) < RDATA_DEPTH → RD_CMD.
    - Head is a read and the reservation is full → stay in IDLE.
  - WR_CMD:
    - Assert mem_en_o, mem_cmd_o=000, mem_addr_o={head.addr[ADDR_WIDTH-1:2],2'b0}.
    - Assert mem_wdf_wren_o with the wdata head, driven concurrently.
    - Command handshake (en&rdy) and data handshake (wren&wdf_rdy) complete independently; each is deasserted after its own handshake.
    - When both have completed: pop both FIFOs; go to IDLE. The earliest next command is the following cycle.
  - RD_CMD:
    - Assert mem_en_o, mem_cmd_o=001 until mem_rdy_i.
    - On handshake: pop cmd FIFO, outstanding+1, go to IDLE.
- Read return:
  - Each mem_rd_data_valid_i writes mem_rd_data_i into the rfifo and decrements outstanding.
  - Increment and decrement in the same cycle: outstanding unchanged.
  - The reservation guarantees the rfifo never overflows.
  - read_data_o and read_valid_o are valid 1 cycle after the beat arrives (registered FIFO).
  - pull_i pops the head; the next head is visible in the following cycle.
  - pull_i on an empty rfifo is ignored.
- ready_o, registered:
  - Set when the cmd FIFO, wdata FIFO and rfifo are all empty, outstanding==0 and the FSM is IDLE.
  - Cleared the cycle after any write_i/read_i/push_i.
- Outstanding counter: $clog2(RDATA_DEPTH)+1 bits; saturates at RDATA_DEPTH (unreachable in correct operation).
- Async reset mid-transaction: everything is cleared immediately; in-flight UI reads returned afterwards are discarded, because outstanding==0 blocks rfifo writes until the first new read is issued.
- burst_open: set on read_i, cleared on done_i. It has no functional effect except under the optional checker.

Optional Feature:
- Macro: DDR_RESPONDER_CHECK_EN.
- When defined, adds output protocol_error_o (1 bit, sticky, reset 0). It sets on any of:
  - write_i & read_i in the same cycle;
  - push to a full FIFO;
  - pull_i with read_valid_o=0;
  - mem_rd_data_valid_i with outstanding==0;
  - done_i while burst_open=0.
- Flagging does not alter datapath behaviour.
- When undefined, the port and logic are absent.

Test Plan:
- Single write:
  - Stimulus: write_i addr=0x0000010, push_i data=0x11223344_55667788 mask=8'h0F; mem_rdy_i=mem_wdf_rdy_i=1.
  - Required: mem_en_o and mem_wdf_wren_o high for one cycle, mem_addr_o=0x0000010, mem_wdf_mask_o=8'hF0, mem_wdf_end_o=1; ready_o returns to 1.
- Split handshake:
  - Stimulus: mem_rdy_i=1 in cycle 0, mem_wdf_rdy_i delayed 3 cycles.
  - Required: mem_en_o drops after cycle 0; mem_wdf_wren_o is held 4 cycles; FIFOs pop only after the data handshake.
- Read burst of 4:
  - Stimulus: read_i at addr 0x20, 0x24, 0x28, 0x2C, then done_i; the UI returns beats 0xA..0xD 5 cycles later.
  - Required: read_valid_o rises; pulling 4 times yields 0xA,0xB,0xC,0xD in order; ready_o=1 afterwards.
- Backpressure:
  - Stimulus: mem_rdy_i=0 for 10 cycles with 3 queued reads.
  - Required: mem_en_o held and mem_addr_o stable at 0x20; no commands are lost.
- Read-FIFO reservation:
  - Stimulus: RDATA_DEPTH=8 with 10 queued reads and no pulls.
  - Required: exactly 8 UI read commands are issued; the 9th is issued only after the first pull.
- Error check (DDR_RESPONDER_CHECK_EN):
  - Stimulus: pull_i with an empty rfifo.
  - Required: protocol_error_o=1 next cycle and stays 1 until reset.
